power_sequencer: RTL and testbench
==================================

# power_sequencer

Staged rail-enable sequencer driving `NUM_STAGES` power/reset enables from a single power request. It ramps the enables up in order with a fixed inter-stage delay and ramps them down in reverse order with the same delay. It sits beside `poweron_delay` at the board-control level. `poweron_delay` gates the request; this block sequences rails for the sensor/ADC front end and reports power-good.

## Interface

Parameters:
- `SYSCLK_FREQ`, default 125: system clock frequency in MHz.
- `STEP_TIME`, default 1000: inter-stage delay in µs.
- `NUM_STAGES`, default 4: number of sequenced enables, legal range 1..16.

Ports:
- `i_Sys_clk`, in, 1: system clock; the only clock.
- `i_Rst`, in, 1: reset. One clock; reset is synchronous and active-high.
- `i_Pwr_req`, in, 1: level request; 1 = power up, 0 = power down. Synchronous to `i_Sys_clk`.
- `i_Fault`, in, 1: fault flag, level, synchronous.
- `o_Rail_en`, out, `NUM_STAGES`: enables; bit 0 rises first and falls last.
- `o_Pwr_good`, out, 1: all rails up, state ON.
- `o_Pwr_off`, out, 1: all rails down, state OFF.
- `o_Busy`, out, 1: RAMP_UP or RAMP_DOWN.
- `o_Fault_latched`, out, 1: state FAULT.

## Operation

- `STEP_CNT = STEP_TIME*SYSCLK_FREQ`.
  - Step counter is 31 bits and counts 0..STEP_CNT-1.
  - `STEP_CNT` must be ≥ 1 and < 2^31; elaboration error otherwise.
- Stage index `idx` is a 5-bit register holding the number of rails currently enabled.
- OFF:
  - Rails are 0, `cnt` = 0, `idx` = 0.
  - `i_Pwr_req` = 1 → RAMP_UP.
- RAMP_UP:
  - `cnt` increments each cycle.
  - At `cnt` == STEP_CNT-1: set `o_Rail_en[idx]`, `idx`++, `cnt` ← 0.
  - If that was the last rail, go to ON on the same edge.
  - `i_Pwr_req` = 0 (abort): go to RAMP_DOWN with `cnt` ← 0; no further rail rises.
    - Exception: if `idx` == 0, go directly to OFF.
- ON: hold all rails. `i_Pwr_req` = 0 → RAMP_DOWN with `cnt` ← 0.
- RAMP_DOWN:
  - At `cnt` == STEP_CNT-1: clear `o_Rail_en[idx-1]`, `idx`--, `cnt` ← 0.
  - When `idx` reaches 0, go to OFF on the same edge.
  - `i_Pwr_req` returning to 1 is ignored; the ramp completes to OFF, then OFF re-enters RAMP_UP on the next cycle if req is still 1.
- FAULT (only with the macro enabled):
  - `i_Fault` = 1 in any state other than FAULT: next edge clears all rails, `idx` ← 0, `cnt` ← 0, state ← FAULT.
  - Fault takes priority over every other transition.
  - FAULT exits to OFF only when `i_Fault` = 0 and `i_Pwr_req` = 0 are seen on the same cycle.
- Outputs are decoded directly from registered state, with no extra pipeline stage:
  - `o_Pwr_good` = (ON)
  - `o_Pwr_off` = (OFF)
  - `o_Busy` = (RAMP_UP | RAMP_DOWN)
  - `o_Fault_latched` = (FAULT)

## Timing

- Reset, synchronous, checked on every edge and overriding all else:
  - State ← OFF, `o_Rail_en` ← 0, `cnt` ← 0, `idx` ← 0.
  - Output values after reset: `o_Pwr_off` = 1, `o_Pwr_good` = 0, `o_Busy` = 0, `o_Fault_latched` = 0.
  - Reset asserted mid-ramp drops every rail at once, with no reverse sequencing.
- Edge E samples req = 1 in OFF. Then:
  - Rail k rises at edge E + (k+1)·STEP_CNT.
  - `o_Pwr_good` rises on the same edge as the last rail.
- Edge F samples req = 0 in ON. Then:
  - Rail k falls at edge F + (NUM_STAGES−k)·STEP_CNT.
  - `o_Pwr_off` rises with the rail-0 fall.
- Fault response latency: 1 clock from `i_Fault` sampled high to all rails low.
- Rails change at most one bit per edge, except on reset or fault.

## Configuration

- Macro `PWR_SEQ_FAULT_EN`:
  - Defined: `i_Fault` is honoured as described above.
  - Undefined: the `i_Fault` port still exists but is ignored; FAULT is unreachable and `o_Fault_latched` is tied 0.

## Structure

- Package `pwr_seq_pkg` holds:
  - State enum: OFF, RAMP_UP, ON, RAMP_DOWN, FAULT (3-bit encoding).
  - `CNT_W` = 31 and `IDX_W` = 5 localparams.
- Sub-module `pwr_step_timer` holds the 31-bit counter, with a clear input and a terminal-count pulse (`cnt` == STEP_CNT-1).
  - The FSM in `power_sequencer` consumes the terminal-count pulse.

## Test plan

Parameters for all scenarios: `SYSCLK_FREQ`=1, `STEP_TIME`=4, `NUM_STAGES`=3, giving STEP_CNT = 4.

- Reset release, then req = 1 at edge 0:
  - `o_Rail_en` = 001 at edge 4, 011 at edge 8, 111 at edge 12.
  - `o_Pwr_good` = 1 at edge 12; `o_Busy` = 1 over edges 1..11.
- From ON, req = 0 at edge 0:
  - `o_Rail_en` = 011 at edge 4, 001 at edge 8, 000 at edge 12.
  - `o_Pwr_off` = 1 at edge 12.
- Abort: req = 1 at edge 0, req = 0 at edge 6 (rails = 001):
  - RAMP_DOWN from edge 6; rail 0 falls at edge 10; OFF at edge 10.
- Abort before first step: req pulsed high for 2 cycles → OFF after 2 cycles, rails never rise.
- With `PWR_SEQ_FAULT_EN`, `i_Fault` = 1 while rails = 011:
  - Next edge: rails = 000, `o_Fault_latched` = 1.
  - Stays in FAULT while req = 1; exits to OFF one edge after fault = 0 and req = 0.
- Sync reset asserted mid RAMP_UP (rails = 011):
  - Next edge: rails = 000, `o_Pwr_off` = 1.
  - After release with req held 1, rail 0 rises STEP_CNT+1 edges later.

Source files
------------

// File: rtl/pwr_seq_pkg.sv
// pwr_seq_pkg: shared constants for the staged rail sequencer.
//   CNT_W   - width of the inter-stage step counter
//   IDX_W   - width of the "rails currently enabled" index (covers 0..16)
//   state_t - sequencer state encoding (3 bits)
package pwr_seq_pkg;

    localparam int unsigned CNT_W = 31;
    localparam int unsigned IDX_W = 5;

    typedef logic [2:0] state_t;

    localparam state_t StOff      = 3'd0;
    localparam state_t StRampUp   = 3'd1;
    localparam state_t StOn       = 3'd2;
    localparam state_t StRampDown = 3'd3;
    localparam state_t StFault    = 3'd4;

endpackage

// File: rtl/pwr_step_timer.sv
// pwr_step_timer: free-running inter-stage step counter, 0..StepLast.
//   i_Sys_clk - system clock
//   i_Rst     - synchronous active-high reset
//   i_Clr     - hold the counter at zero
//   o_Tc      - terminal count, high while the counter equals StepLast
module pwr_step_timer
    import pwr_seq_pkg::*;
#(
    parameter logic [CNT_W-1:0] StepLast = '0
) (
    input  logic i_Sys_clk,
    input  logic i_Rst,
    input  logic i_Clr,
    output logic o_Tc
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign o_Tc = (cnt_q == StepLast);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (i_Clr || o_Tc) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge i_Sys_clk) begin
        if (i_Rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/power_sequencer.sv
// power_sequencer: ramps NUM_STAGES rail enables up in order (bit 0 first) and down in
// reverse order, one rail per STEP_TIME*SYSCLK_FREQ clocks, from a level power request.
//   i_Sys_clk       - system clock
//   i_Rst           - synchronous active-high reset
//   i_Pwr_req       - 1 = power up, 0 = power down
//   i_Fault         - fault flag (honoured only when PWR_SEQ_FAULT_EN is defined)
//   o_Rail_en       - rail enables
//   o_Pwr_good      - all rails up (ON)
//   o_Pwr_off       - all rails down (OFF)
//   o_Busy          - ramping up or down
//   o_Fault_latched - in FAULT
// Build option: define PWR_SEQ_FAULT_EN to enable the fault latch; otherwise i_Fault is
// ignored and o_Fault_latched is tied low.
module power_sequencer
    import pwr_seq_pkg::*;
#(
    parameter int unsigned SYSCLK_FREQ = 125,
    parameter int unsigned STEP_TIME   = 1000,
    parameter int unsigned NUM_STAGES  = 4
) (
    input  logic                  i_Sys_clk,
    input  logic                  i_Rst,
    input  logic                  i_Pwr_req,
    input  logic                  i_Fault,
    output logic [NUM_STAGES-1:0] o_Rail_en,
    output logic                  o_Pwr_good,
    output logic                  o_Pwr_off,
    output logic                  o_Busy,
    output logic                  o_Fault_latched
);

    localparam longint unsigned StepCnt = longint'(STEP_TIME) * longint'(SYSCLK_FREQ);
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_STAGES - 1);

    if (StepCnt < 64'd1 || StepCnt > 64'h7FFF_FFFF) begin : gen_bad_step
        $error("power_sequencer: STEP_TIME*SYSCLK_FREQ must be in 1..2^31-1");
    end
    if (NUM_STAGES < 1 || NUM_STAGES > 16) begin : gen_bad_stages
        $error("power_sequencer: NUM_STAGES must be in 1..16");
    end

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NUM_STAGES-1:0]   rail_q, rail_d;
    logic                    step_clr;
    logic                    step_tc;

    pwr_step_timer #(
        .StepLast(CNT_W'(StepCnt - 64'd1))
    ) u_step_timer (
        .i_Sys_clk(i_Sys_clk),
        .i_Rst    (i_Rst),
        .i_Clr    (step_clr),
        .o_Tc     (step_tc)
    );

    // Rails are always a thermometer code of idx_q ones from bit 0, so a single shift
    // raises the next rail or drops the highest one.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        rail_d   = rail_q;
        step_clr = 1'b0;

        case (state_q)
            StOff: begin
                step_clr = 1'b1;
                if (i_Pwr_req) begin
                    state_d = StRampUp;
                end
            end
            StRampUp: begin
                if (!i_Pwr_req) begin
                    // Abort wins over a coincident step; nothing to ramp down if no rail is up.
                    step_clr = 1'b1;
                    state_d  = (idx_q == '0) ? StOff : StRampDown;
                end else if (step_tc) begin
                    rail_d = (rail_q << 1) | NUM_STAGES'(1);
                    idx_d  = idx_q + IDX_W'(1);
                    if (idx_q == LastIdx) begin
                        state_d = StOn;
                    end
                end
            end
            StOn: begin
                step_clr = 1'b1;
                if (!i_Pwr_req) begin
                    state_d = StRampDown;
                end
            end
            StRampDown: begin
                // Request is ignored here; the ramp always runs to OFF.
                if (step_tc) begin
                    rail_d = rail_q >> 1;
                    idx_d  = idx_q - IDX_W'(1);
                    if (idx_q == IDX_W'(1)) begin
                        state_d = StOff;
                    end
                end
            end
            StFault: begin
                step_clr = 1'b1;
`ifdef PWR_SEQ_FAULT_EN
                if (!i_Fault && !i_Pwr_req) begin
                    state_d = StOff;
                end
`else
                state_d = StOff;
`endif
            end
            default: begin
                step_clr = 1'b1;
                state_d  = StOff;
                idx_d    = '0;
                rail_d   = '0;
            end
        endcase

`ifdef PWR_SEQ_FAULT_EN
        if (i_Fault && (state_q != StFault)) begin
            state_d  = StFault;
            idx_d    = '0;
            rail_d   = '0;
            step_clr = 1'b1;
        end
`endif
    end

    always_ff @(posedge i_Sys_clk) begin
        if (i_Rst) begin
            state_q <= StOff;
            idx_q   <= '0;
            rail_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rail_q  <= rail_d;
        end
    end

    assign o_Rail_en  = rail_q;
    assign o_Pwr_good = (state_q == StOn);
    assign o_Pwr_off  = (state_q == StOff);
    assign o_Busy     = (state_q == StRampUp) || (state_q == StRampDown);

`ifdef PWR_SEQ_FAULT_EN
    assign o_Fault_latched = (state_q == StFault);
`else
    assign o_Fault_latched = 1'b0;
    logic unused_fault;
    assign unused_fault = i_Fault;
`endif

endmodule

// File: tb/tb_power_sequencer.sv
module tb_power_sequencer;

    localparam int S = 4;
    localparam int N = 3;
    localparam int MOff = 0, MUp = 1, MOn = 2, MDown = 3, MFault = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req = 1'b0;
    logic flt = 1'b0;
    logic [N-1:0] rail;
    logic good, off, busy, flatch;
    logic [N+3:0] act;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: phase plus edges elapsed in that phase; rail count is elapsed/S.
    int m_mode = MOff;
    int m_n = 0;
    int m_base = 0;
    int m_e = 0;

    power_sequencer #(
        .SYSCLK_FREQ(1),
        .STEP_TIME  (4),
        .NUM_STAGES (N)
    ) dut (
        .i_Sys_clk      (clk),
        .i_Rst          (rst),
        .i_Pwr_req      (req),
        .i_Fault        (flt),
        .o_Rail_en      (rail),
        .o_Pwr_good     (good),
        .o_Pwr_off      (off),
        .o_Busy         (busy),
        .o_Fault_latched(flatch)
    );

    always #5 clk = ~clk;

    assign act = {rail, good, off, busy, flatch};

    task automatic model_edge(input logic r_rst, input logic r_req, input logic r_flt);
        bit fault_en;
`ifdef PWR_SEQ_FAULT_EN
        fault_en = 1'b1;
`else
        fault_en = 1'b0;
`endif
        if (r_rst) begin
            m_mode = MOff; m_n = 0; m_e = 0;
        end else if (fault_en && r_flt && m_mode != MFault) begin
            m_mode = MFault; m_n = 0; m_e = 0;
        end else begin
            case (m_mode)
                MOff: if (r_req) begin m_mode = MUp; m_e = 0; m_n = 0; end
                MUp: begin
                    if (!r_req) begin
                        if (m_n == 0) m_mode = MOff;
                        else begin m_mode = MDown; m_base = m_n; m_e = 0; end
                    end else begin
                        m_e++;
                        m_n = m_e / S;
                        if (m_n == N) m_mode = MOn;
                    end
                end
                MOn: if (!r_req) begin m_mode = MDown; m_base = N; m_e = 0; end
                MDown: begin
                    m_e++;
                    m_n = m_base - m_e / S;
                    if (m_n == 0) m_mode = MOff;
                end
                default: if (!r_flt && !r_req) m_mode = MOff;
            endcase
        end
    endtask

    function automatic logic [N+3:0] model_vec();
        logic [N-1:0] r;
        r = N'((1 << m_n) - 1);
        return {r, m_mode == MOn, m_mode == MOff, (m_mode == MUp) || (m_mode == MDown),
                m_mode == MFault};
    endfunction

    task automatic step(input logic r_rst, input logic r_req, input logic r_flt);
        rst = r_rst; req = r_req; flt = r_flt;
        @(posedge clk);
        model_edge(r_rst, r_req, r_flt);
        #1;
    endtask

    task automatic test_reset();
        logic [N+3:0] want;
        want = {{N{1'b0}}, 4'b0100};
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (act !== want) begin
            n_fail++; $display("FAIL reset_state: got %b want %b", act, want);
        end
        step(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (act !== want) begin
            n_fail++; $display("FAIL reset_idle: got %b want %b", act, want);
        end
    endtask

    task automatic test_ramp_up();
        logic [N-1:0] want_r [3];
        want_r = '{3'b001, 3'b011, 3'b111};
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0);
        for (int e = 0; e <= 12; e++) begin
            step(1'b0, 1'b1, 1'b0);
            n_cmp++;
            if (act !== model_vec()) begin
                n_fail++; $display("FAIL ramp_up edge %0d: got %b want %b", e, act, model_vec());
            end
            if (e == 4 || e == 8 || e == 12) begin
                n_cmp++;
                if (rail !== want_r[e/4-1]) begin
                    n_fail++;
                    $display("FAIL ramp_up_rail edge %0d: got %b want %b", e, rail, want_r[e/4-1]);
                end
            end
            if (e >= 1 && e <= 11) begin
                n_cmp++;
                if (busy !== 1'b1 || good !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ramp_up_busy edge %0d: got busy=%b good=%b want 1 0", e, busy, good);
                end
            end
        end
        n_cmp++;
        if (good !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL ramp_up_good: got good=%b busy=%b want 1 0", good, busy);
        end
    endtask

    task automatic test_ramp_down();
        logic [N-1:0] want_r [3];
        want_r = '{3'b011, 3'b001, 3'b000};
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 13; i++) step(1'b0, 1'b1, 1'b0);
        for (int e = 0; e <= 12; e++) begin
            step(1'b0, 1'b0, 1'b0);
            n_cmp++;
            if (act !== model_vec()) begin
                n_fail++; $display("FAIL ramp_down edge %0d: got %b want %b", e, act, model_vec());
            end
            if (e == 4 || e == 8 || e == 12) begin
                n_cmp++;
                if (rail !== want_r[e/4-1]) begin
                    n_fail++;
                    $display("FAIL ramp_down_rail edge %0d: got %b want %b", e, rail, want_r[e/4-1]);
                end
            end
        end
        n_cmp++;
        if (off !== 1'b1) begin
            n_fail++; $display("FAIL ramp_down_off: got %b want 1", off);
        end
    endtask

    task automatic test_abort();
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0);
        for (int e = 0; e <= 12; e++) begin
            step(1'b0, (e < 6), 1'b0);
            n_cmp++;
            if (act !== model_vec()) begin
                n_fail++; $display("FAIL abort edge %0d: got %b want %b", e, act, model_vec());
            end
            if (e == 9) begin
                n_cmp++;
                if (rail !== 3'b001 || busy !== 1'b1) begin
                    n_fail++; $display("FAIL abort_hold: got rail=%b busy=%b want 001 1", rail, busy);
                end
            end
            if (e == 10) begin
                n_cmp++;
                if (rail !== 3'b000 || off !== 1'b1) begin
                    n_fail++; $display("FAIL abort_off: got rail=%b off=%b want 000 1", rail, off);
                end
            end
        end
    endtask

    task automatic test_abort_early();
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0);
        for (int e = 0; e < 10; e++) begin
            step(1'b0, (e < 2), 1'b0);
            n_cmp++;
            if (rail !== 3'b000 || act !== model_vec()) begin
                n_fail++; $display("FAIL abort_early edge %0d: got %b want %b", e, act, model_vec());
            end
            if (e == 2) begin
                n_cmp++;
                if (off !== 1'b1) begin
                    n_fail++; $display("FAIL abort_early_off: got %b want 1", off);
                end
            end
        end
    endtask

    task automatic test_down_ignores_req();
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 13; i++) step(1'b0, 1'b1, 1'b0);
        for (int e = 0; e <= 17; e++) begin
            step(1'b0, (e >= 2), 1'b0);
            n_cmp++;
            if (act !== model_vec()) begin
                n_fail++; $display("FAIL down_ignore edge %0d: got %b want %b", e, act, model_vec());
            end
        end
        n_cmp++;
        if (rail !== 3'b001 || busy !== 1'b1) begin
            n_fail++; $display("FAIL down_ignore_reup: got rail=%b busy=%b want 001 1", rail, busy);
        end
    endtask

    task automatic test_reset_mid_ramp();
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (rail !== 3'b011) begin
            n_fail++; $display("FAIL rst_mid_pre: got %b want 011", rail);
        end
        step(1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (rail !== 3'b000 || off !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_drop: got rail=%b off=%b want 000 1", rail, off);
        end
        for (int k = 1; k <= S + 1; k++) begin
            step(1'b0, 1'b1, 1'b0);
            n_cmp++;
            if (act !== model_vec() || rail !== ((k == S + 1) ? 3'b001 : 3'b000)) begin
                n_fail++; $display("FAIL rst_mid_reup +%0d: got %b want %b", k, act, model_vec());
            end
        end
    endtask

    task automatic test_fault();
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        n_cmp++;
`ifdef PWR_SEQ_FAULT_EN
        if (rail !== 3'b000 || flatch !== 1'b1) begin
            n_fail++; $display("FAIL fault_hit: got rail=%b latched=%b want 000 1", rail, flatch);
        end
`else
        if (rail !== 3'b011 || flatch !== 1'b0) begin
            n_fail++; $display("FAIL fault_ignored: got rail=%b latched=%b want 011 0", rail, flatch);
        end
`endif
        for (int e = 0; e < 6; e++) begin
            step(1'b0, 1'b1, (e < 2));
            n_cmp++;
            if (act !== model_vec()) begin
                n_fail++; $display("FAIL fault_hold edge %0d: got %b want %b", e, act, model_vec());
            end
        end
        step(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (act !== model_vec()) begin
            n_fail++; $display("FAIL fault_exit: got %b want %b", act, model_vec());
        end
`ifdef PWR_SEQ_FAULT_EN
        n_cmp++;
        if (off !== 1'b1 || flatch !== 1'b0) begin
            n_fail++; $display("FAIL fault_exit_off: got off=%b latched=%b want 1 0", off, flatch);
        end
`endif
    endtask

    task automatic test_random();
        logic r_req;
        int hold;
        r_req = 1'b0;
        hold = 0;
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                r_req = $urandom_range(0, 1) == 1;
                hold = $urandom_range(1, 30);
            end
            hold--;
            step(($urandom_range(0, 399) == 0), r_req, ($urandom_range(0, 79) == 0));
            n_cmp++;
            if (act !== model_vec()) begin
                n_fail++; $display("FAIL random cycle %0d: got %b want %b", c, act, model_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_ramp_down();
        test_abort();
        test_abort_early();
        test_down_ignores_req();
        test_reset_mid_ramp();
        test_fault();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
